// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Purpose:
//   Decodes 32-bit instructions, reads operands from an 8x32 register file,
//   tracks in-flight destinations with a pending scoreboard, stalls on
//   hazards and issues registered operands to the execute stage.
//
// Ports:
//   clock        in   1   single clock, all state updates on rising edge
//   reset        in   1   asynchronous active-high reset
//   in_instr     in  32   instruction word
//   in_valid     in   1   in_instr is valid
//   in_ready     out  1   block can accept in_instr this cycle
//   wb_en        in   1   writeback strobe from downstream
//   wb_addr      in   3   writeback destination register
//   wb_data      in  32   writeback value
//   op0          out 32   first operand to execute
//   op1          out 32   second operand to execute
//   sel          out  1   1 = add, 0 = subtract
//   dest         out  3   destination register of the issued instruction
//   out_valid    out  1   op0/op1/sel/dest carry an issued instruction
//   issue_count  out 16   number of issued instructions, wrapping
// ---------------------------------------------------------------------------
module decode_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_instr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        wb_en,
    input  logic [2:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [31:0] op0,
    output logic [31:0] op1,
    output logic        sel,
    output logic [2:0]  dest,
    output logic        out_valid,
    output logic [15:0] issue_count
);

    typedef enum logic [3:0] {
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_LI  = 4'h3
    } opcode_t;

    logic [31:0] r_regs [8];
    logic [7:0]  r_pending;
    logic [31:0] r_op0;
    logic [31:0] r_op1;
    logic        r_sel;
    logic [2:0]  r_dest;
    logic        r_outValid;
    logic [15:0] r_issueCount;

    logic [3:0]  w_opcode;
    logic [2:0]  w_rd;
    logic [2:0]  w_rs0;
    logic [2:0]  w_rs1;
    logic [15:0] w_imm;
    logic        w_isAlu;
    logic        w_isLi;
    logic        w_isOp;
    logic [7:0]  w_clearMask;
    logic [7:0]  w_setMask;
    logic [7:0]  w_pendEff;
    logic        w_stall;
    logic        w_issue;
    logic [31:0] w_rs0Val;
    logic [31:0] w_rs1Val;
    logic [31:0] w_nextOp0;
    logic [31:0] w_nextOp1;
    logic        w_nextSel;

    // Field extraction; bits [18:16] are unused by every opcode.
    assign w_opcode = in_instr[31:28];
    assign w_rd     = in_instr[27:25];
    assign w_rs0    = in_instr[24:22];
    assign w_rs1    = in_instr[21:19];
    assign w_imm    = in_instr[15:0];

    assign w_isAlu = (w_opcode == OP_ADD) || (w_opcode == OP_SUB);
    assign w_isLi  = (w_opcode == OP_LI);
    assign w_isOp  = w_isAlu || w_isLi;

    // A writeback on this edge already resolves its register, so the hazard
    // check looks at the scoreboard with that bit removed.
    assign w_clearMask = wb_en ? (8'b1 << wb_addr) : 8'b0;
    assign w_pendEff   = r_pending & ~w_clearMask;

    // Hazard detection; NOPs never stall, and an idle input never stalls.
    always_comb begin
        w_stall = 1'b0;
        if (in_valid) begin
            if (w_isAlu) begin
                w_stall = w_pendEff[w_rs0] | w_pendEff[w_rs1] | w_pendEff[w_rd];
            end else if (w_isLi) begin
                w_stall = w_pendEff[w_rd];
            end
        end
    end

    assign in_ready = !reset && !w_stall;
    assign w_issue  = in_valid && in_ready && w_isOp;

    // Scoreboard set for the issuing destination; R0 is never tracked.
    assign w_setMask = (w_issue && (w_rd != 3'd0)) ? (8'b1 << w_rd) : 8'b0;

    // Operand read with same-cycle writeback bypass; R0 always reads zero.
    always_comb begin
        w_rs0Val = r_regs[w_rs0];
        w_rs1Val = r_regs[w_rs1];
        if (w_rs0 == 3'd0) begin
            w_rs0Val = 32'h0;
        end else if (wb_en && (wb_addr == w_rs0)) begin
            w_rs0Val = wb_data;
        end
        if (w_rs1 == 3'd0) begin
            w_rs1Val = 32'h0;
        end else if (wb_en && (wb_addr == w_rs1)) begin
            w_rs1Val = wb_data;
        end
    end

    // Operand and select selection for the instruction being issued.
    always_comb begin
        w_nextOp0 = w_rs0Val;
        w_nextOp1 = w_rs1Val;
        w_nextSel = 1'b1;
        if (w_isLi) begin
            w_nextOp0 = {16'h0, w_imm};
            w_nextOp1 = 32'h0;
        end else if (w_opcode == OP_SUB) begin
            w_nextSel = 1'b0;
        end
    end

    // Register file; entry 0 is held at zero and never written.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 32'h0;
            end
        end else if (wb_en && (wb_addr != 3'd0)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Scoreboard update; applying the set after the clear lets an issue win
    // over a writeback to the same register on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending <= 8'h0;
        end else begin
            r_pending <= ((r_pending & ~w_clearMask) | w_setMask) & 8'hFE;
        end
    end

    // Issue pipeline register; payload holds its value between issues.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op0        <= 32'h0;
            r_op1        <= 32'h0;
            r_sel        <= 1'b0;
            r_dest       <= 3'd0;
            r_outValid   <= 1'b0;
            r_issueCount <= 16'h0;
        end else begin
            r_outValid <= w_issue;
            if (w_issue) begin
                r_op0        <= w_nextOp0;
                r_op1        <= w_nextOp1;
                r_sel        <= w_nextSel;
                r_dest       <= w_rd;
                r_issueCount <= r_issueCount + 16'd1;
            end
        end
    end

    assign op0         = r_op0;
    assign op1         = r_op1;
    assign sel         = r_sel;
    assign dest        = r_dest;
    assign out_valid   = r_outValid;
    assign issue_count = r_issueCount;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Purpose:
//   Directed self-checking bench for decode_stage: reset state, LI issue,
//   RAW stall with bypass, R0 handling, set/clear race, NOP acceptance,
//   issue_count wrap and reset during a stall.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    logic        clock;
    logic        reset;
    logic [31:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] op0;
    logic [31:0] op1;
    logic        sel;
    logic [2:0]  dest;
    logic        out_valid;
    logic [15:0] issue_count;

    int checkCount;
    int errorCount;

    decode_stage dut (
        .clock       (clock),
        .reset       (reset),
        .in_instr    (in_instr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .op0         (op0),
        .op1         (op1),
        .sel         (sel),
        .dest        (dest),
        .out_valid   (out_valid),
        .issue_count (issue_count)
    );

    // 10-unit clock period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Instruction encoder.
    function automatic logic [31:0] mkInstr(input logic [3:0] op, input logic [2:0] rd,
                                            input logic [2:0] rs0, input logic [2:0] rs1,
                                            input logic [15:0] imm);
        return {op, rd, rs0, rs1, 3'b000, imm};
    endfunction

    // Reset with idle inputs; release away from the rising edge.
    task automatic doReset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_instr = 32'h0;
        wb_en    = 1'b0;
        wb_addr  = 3'd0;
        wb_data  = 32'h0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    // Advance one rising edge and settle.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_instr = mkInstr(4'h3, 3'd1, 3'd0, 3'd0, 16'd5);
        wb_en    = 1'b0;
        wb_addr  = 3'd0;
        wb_data  = 32'h0;
        step();
        checkCount++;
        if (in_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
        checkCount++;
        if (out_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checkCount++;
        if (issue_count !== 16'h0) begin errorCount++; $display("[TB] FAIL reset_count: got %h expected 0000", issue_count); end
        checkCount++;
        if ({op0, op1, sel, dest} !== 68'h0) begin errorCount++; $display("[TB] FAIL reset_payload: got %h %h %b %h expected zeros", op0, op1, sel, dest); end
        doReset();
    endtask

    task automatic test_li_back_to_back();
        doReset();
        in_valid = 1'b1;
        in_instr = mkInstr(4'h3, 3'd1, 3'd0, 3'd0, 16'd5);
        #1;
        checkCount++;
        if (in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL li1_ready: got %b expected 1", in_ready); end
        step();
        checkCount++;
        if ({out_valid, op0, op1, sel, dest} !== {1'b1, 32'd5, 32'd0, 1'b1, 3'd1}) begin
            errorCount++; $display("[TB] FAIL li1_out: got v=%b %h %h %b %h expected v=1 5 0 1 1", out_valid, op0, op1, sel, dest);
        end
        in_instr = mkInstr(4'h3, 3'd2, 3'd0, 3'd0, 16'd7);
        #1;
        checkCount++;
        if (in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL li2_ready: got %b expected 1", in_ready); end
        step();
        checkCount++;
        if ({out_valid, op0, op1, sel, dest} !== {1'b1, 32'd7, 32'd0, 1'b1, 3'd2}) begin
            errorCount++; $display("[TB] FAIL li2_out: got v=%b %h %h %b %h expected v=1 7 0 1 2", out_valid, op0, op1, sel, dest);
        end
        checkCount++;
        if (issue_count !== 16'd2) begin errorCount++; $display("[TB] FAIL li_count: got %0d expected 2", issue_count); end
        in_valid = 1'b0;
        step();
        checkCount++;
        if ({out_valid, op0, dest} !== {1'b0, 32'd7, 3'd2}) begin
            errorCount++; $display("[TB] FAIL li_hold: got v=%b %h %h expected v=0 7 2", out_valid, op0, dest);
        end
    endtask

    task automatic test_raw_stall();
        doReset();
        in_valid = 1'b1;
        in_instr = mkInstr(4'h3, 3'd1, 3'd0, 3'd0, 16'd5);
        step();
        in_instr = mkInstr(4'h1, 3'd3, 3'd1, 3'd1, 16'd0);
        #1;
        checkCount++;
        if (in_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL raw_stall_ready: got %b expected 0", in_ready); end
        step();
        checkCount++;
        if ({out_valid, in_ready} !== 2'b00) begin errorCount++; $display("[TB] FAIL raw_stall_hold: got v=%b r=%b expected 0 0", out_valid, in_ready); end
        wb_en   = 1'b1;
        wb_addr = 3'd1;
        wb_data = 32'd5;
        #1;
        checkCount++;
        if (in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL raw_wb_ready: got %b expected 1", in_ready); end
        step();
        wb_en    = 1'b0;
        in_valid = 1'b0;
        checkCount++;
        if ({out_valid, op0, op1, sel, dest} !== {1'b1, 32'd5, 32'd5, 1'b1, 3'd3}) begin
            errorCount++; $display("[TB] FAIL raw_add_out: got v=%b %h %h %b %h expected v=1 5 5 1 3", out_valid, op0, op1, sel, dest);
        end
        checkCount++;
        if (issue_count !== 16'd2) begin errorCount++; $display("[TB] FAIL raw_count: got %0d expected 2", issue_count); end
    endtask

    task automatic test_nop();
        // R3 is pending from the ADD above; a NOP naming R3 still goes through.
        in_valid = 1'b1;
        in_instr = mkInstr(4'h0, 3'd3, 3'd3, 3'd3, 16'hFFFF);
        #1;
        checkCount++;
        if (in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL nop_ready: got %b expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        checkCount++;
        if ({out_valid, issue_count} !== {1'b0, 16'd2}) begin
            errorCount++; $display("[TB] FAIL nop_out: got v=%b cnt=%0d expected v=0 cnt=2", out_valid, issue_count);
        end
        // A real instruction on R3 still stalls.
        in_valid = 1'b1;
        in_instr = mkInstr(4'h3, 3'd3, 3'd0, 3'd0, 16'd1);
        #1;
        checkCount++;
        if (in_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL nop_pending_kept: got %b expected 0", in_ready); end
        in_valid = 1'b0;
    endtask

    task automatic test_r0();
        doReset();
        wb_en   = 1'b1;
        wb_addr = 3'd0;
        wb_data = 32'hDEAD;
        step();
        wb_en    = 1'b0;
        in_valid = 1'b1;
        in_instr = mkInstr(4'h2, 3'd4, 3'd0, 3'd0, 16'd0);
        #1;
        checkCount++;
        if (in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL r0_ready: got %b expected 1", in_ready); end
        step();
        checkCount++;
        if ({out_valid, op0, op1, sel, dest} !== {1'b1, 32'd0, 32'd0, 1'b0, 3'd4}) begin
            errorCount++; $display("[TB] FAIL r0_sub_out: got v=%b %h %h %b %h expected v=1 0 0 0 4", out_valid, op0, op1, sel, dest);
        end
        // Writeback to R0 in the issuing cycle must not bypass into operands.
        wb_en    = 1'b1;
        wb_addr  = 3'd0;
        wb_data  = 32'hBEEF;
        in_instr = mkInstr(4'h1, 3'd5, 3'd0, 3'd0, 16'd0);
        step();
        wb_en    = 1'b0;
        in_valid = 1'b0;
        checkCount++;
        if ({out_valid, op0, op1, sel} !== {1'b1, 32'd0, 32'd0, 1'b1}) begin
            errorCount++; $display("[TB] FAIL r0_no_bypass: got v=%b %h %h %b expected v=1 0 0 1", out_valid, op0, op1, sel);
        end
    endtask

    task automatic test_set_clear();
        doReset();
        in_valid = 1'b1;
        in_instr = mkInstr(4'h3, 3'd2, 3'd0, 3'd0, 16'd3);
        step();
        in_instr = mkInstr(4'h3, 3'd2, 3'd0, 3'd0, 16'd9);
        wb_en    = 1'b1;
        wb_addr  = 3'd2;
        wb_data  = 32'd3;
        #1;
        checkCount++;
        if (in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL setclr_ready: got %b expected 1", in_ready); end
        step();
        wb_en = 1'b0;
        checkCount++;
        if ({out_valid, op0, dest} !== {1'b1, 32'd9, 3'd2}) begin
            errorCount++; $display("[TB] FAIL setclr_li_out: got v=%b %h %h expected v=1 9 2", out_valid, op0, dest);
        end
        in_instr = mkInstr(4'h1, 3'd5, 3'd2, 3'd0, 16'd0);
        #1;
        checkCount++;
        if (in_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL setclr_stall: got %b expected 0", in_ready); end
        step();
        checkCount++;
        if (out_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL setclr_no_issue: got %b expected 0", out_valid); end
        wb_en   = 1'b1;
        wb_addr = 3'd2;
        wb_data = 32'd9;
        step();
        wb_en    = 1'b0;
        in_valid = 1'b0;
        checkCount++;
        if ({out_valid, op0, op1, sel, dest} !== {1'b1, 32'd9, 32'd0, 1'b1, 3'd5}) begin
            errorCount++; $display("[TB] FAIL setclr_add_out: got v=%b %h %h %b %h expected v=1 9 0 1 5", out_valid, op0, op1, sel, dest);
        end
    endtask

    task automatic test_wrap();
        doReset();
        in_valid = 1'b1;
        in_instr = mkInstr(4'h3, 3'd0, 3'd0, 3'd0, 16'd1);
        for (int i = 0; i < 65535; i++) begin
            @(posedge clock);
        end
        #1;
        checkCount++;
        if (issue_count !== 16'hFFFF) begin errorCount++; $display("[TB] FAIL wrap_ffff: got %h expected ffff", issue_count); end
        step();
        in_valid = 1'b0;
        checkCount++;
        if ({out_valid, issue_count} !== {1'b1, 16'h0}) begin
            errorCount++; $display("[TB] FAIL wrap_zero: got v=%b cnt=%h expected v=1 cnt=0000", out_valid, issue_count);
        end
    endtask

    task automatic test_mid_reset();
        doReset();
        in_valid = 1'b1;
        in_instr = mkInstr(4'h3, 3'd1, 3'd0, 3'd0, 16'd5);
        step();
        in_instr = mkInstr(4'h1, 3'd3, 3'd1, 3'd1, 16'd0);
        #1;
        reset = 1'b1;
        #1;
        checkCount++;
        if ({in_ready, out_valid} !== 2'b00) begin
            errorCount++; $display("[TB] FAIL midrst_immediate: got r=%b v=%b expected 0 0", in_ready, out_valid);
        end
        // Writeback during reset must be ignored.
        wb_en   = 1'b1;
        wb_addr = 3'd1;
        wb_data = 32'h55;
        @(posedge clock);
        @(negedge clock);
        wb_en = 1'b0;
        reset = 1'b0;
        #1;
        checkCount++;
        if (in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL midrst_ready_after: got %b expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        checkCount++;
        if ({out_valid, op0, op1, dest, issue_count} !== {1'b1, 32'd0, 32'd0, 3'd3, 16'd1}) begin
            errorCount++; $display("[TB] FAIL midrst_issue: got v=%b %h %h %h cnt=%0d expected v=1 0 0 3 cnt=1", out_valid, op0, op1, dest, issue_count);
        end
    endtask

    // Test sequence.
    initial begin
        checkCount = 0;
        errorCount = 0;
        test_reset();
        test_li_back_to_back();
        test_raw_stall();
        test_nop();
        test_r0();
        test_set_clear();
        test_mid_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
